// File: rtl/cpu_pkg.sv
// Definitions shared between the fetch unit and the decoder: jump encodings,
// fetch FSM states and the default reset PC.
package cpu_pkg;

    localparam logic [1:0] JUMP_SEQ = 2'b00;
    localparam logic [1:0] JUMP_REG = 2'b01;
    localparam logic [1:0] JUMP_ABS = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    // Word offset to byte offset, sign-extended to a full address.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: absolute jump, register jump, BNE or
// sequential. Jumps override the branch flag.
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  jump,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic [15:0] immediate,
    input  logic [25:0] target,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic        jr_misaligned
);

    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        case (jump)
            JUMP_ABS: next_pc = {pc_plus4[31:28], target, 2'b00};
            JUMP_REG: begin
                // Low bits are dropped so the PC stays word aligned.
                next_pc       = {jr_addr[31:2], 2'b00};
                jr_misaligned = |jr_addr[1:0];
            end
            default: begin
                if (branch && !alu_zero) begin
                    next_pc = pc_plus4 + branch_offset(immediate);
                end
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch: fetches one word over a req/ack
// handshake, holds it for the datapath, then advances the PC.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instruction,
    output logic             instr_valid,
    input  logic             instr_ack,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic [1:0]       jump,
    input  logic [15:0]      immediate,
    input  logic [25:0]      target,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             misalign_err,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state;
    logic         req_q;
    logic [31:0]  next_pc;
    logic         jr_misaligned;
    logic         fetch_done;
    logic         issue_done;

    next_pc_logic u_next_pc (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .branch        (branch),
        .alu_zero      (alu_zero),
        .immediate     (immediate),
        .target        (target),
        .jr_addr       (jr_addr),
        .next_pc       (next_pc),
        .jr_misaligned (jr_misaligned)
    );

    assign imem_req    = req_q & rst_n;
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign pc_plus4    = pc + 32'd4;

    // An ack only counts once our own request is visible, so a stale ack
    // straight after reset cannot be captured.
    assign fetch_done = (state == FETCH) && req_q && imem_ack;
    assign issue_done = (state == ISSUE) && instr_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= {RESET_PC[31:2], 2'b00};
            instruction  <= '0;
            req_q        <= 1'b0;
            misalign_err <= 1'b0;
            retired      <= '0;
        end else begin
            if (fetch_done) begin
                instruction <= imem_rdata;
                state       <= ISSUE;
                req_q       <= 1'b0;
            end else if (state == FETCH) begin
                req_q <= 1'b1;
            end

            if (issue_done) begin
                pc      <= next_pc;
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
                state   <= FETCH;
                req_q   <= 1'b1;
                if (jr_misaligned) begin
                    misalign_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of fetch/issue vectors with
// hand-derived next PCs, plus reset corner cases; a 4-bit-counter copy checks wrap.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ack;
    logic        branch;
    logic        alu_zero;
    logic [1:0]  jump;
    logic [15:0] immediate;
    logic [25:0] target;
    logic [31:0] jr_addr;

    logic        imem_req, instr_valid, misalign_err;
    logic [31:0] imem_addr, instruction, pc, pc_plus4, retired;
    logic        imem_req4, instr_valid4, misalign_err4;
    logic [31:0] imem_addr4, instruction4, pc4, pc_plus4_4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_ack(instr_ack), .branch(branch),
        .alu_zero(alu_zero), .jump(jump), .immediate(immediate), .target(target),
        .jr_addr(jr_addr), .pc(pc), .pc_plus4(pc_plus4),
        .misalign_err(misalign_err), .retired(retired)
    );

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction4),
        .instr_valid(instr_valid4), .instr_ack(instr_ack), .branch(branch),
        .alu_zero(alu_zero), .jump(jump), .immediate(immediate), .target(target),
        .jr_addr(jr_addr), .pc(pc4), .pc_plus4(pc_plus4_4),
        .misalign_err(misalign_err4), .retired(retired4)
    );

    typedef struct {
        logic [31:0] rdata;
        int          mem_wait;
        int          hold;
        logic [1:0]  jump;
        logic        branch;
        logic        alu_zero;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] jr;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [16];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] cur_instr;
    logic [31:0] model_pc;
    logic [31:0] model_ret;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_instr(input logic [31:0] rdata, input int mem_wait,
                               input logic [31:0] exp_addr, input int exp_delay);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        check_output("req_delay", 32'(n), 32'(exp_delay));
        check_output("imem_addr", imem_addr, exp_addr);
        check_output("valid_in_fetch", 32'(instr_valid), 32'd0);
        for (int i = 0; i < mem_wait; i++) begin
            step();
            check_output("req_held", 32'(imem_req), 32'd1);
        end
        imem_rdata = rdata;
        imem_ack   = 1'b1;
        sb_q.push_back(rdata);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_output("instr_valid", 32'(instr_valid), 32'd1);
        check_output("req_in_issue", 32'(imem_req), 32'd0);
        if (sb_q.size() == 0) begin
            check_output("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            cur_instr = sb_q.pop_front();
            check_output("instruction", instruction, cur_instr);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        jump      = v.jump;
        branch    = v.branch;
        alu_zero  = v.alu_zero;
        immediate = v.imm;
        target    = v.target;
        jr_addr   = v.jr;
        // Memory acks with junk while the datapath stalls; it must be ignored.
        for (int k = 0; k < v.hold; k++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_0000 + 32'(k);
            step();
            check_output("instr_stable", instruction, cur_instr);
            check_output("valid_held", 32'(instr_valid), 32'd1);
        end
        imem_ack  = 1'b0;
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        model_pc  = v.exp_pc;
        model_ret = model_ret + 32'd1;
        check_output("next_pc", pc, model_pc);
        check_output("pc_plus4", pc_plus4, model_pc + 32'd4);
        check_output("misalign_err", 32'(misalign_err), 32'(v.exp_err));
        check_output("retired", retired, model_ret);
        check_output("retired_w4", {28'd0, retired4}, {28'd0, model_ret[3:0]});
        check_output("pc_w4", pc4, model_pc);
        check_output("valid_after_ack", 32'(instr_valid), 32'd0);
        check_output("req_after_ack", 32'(imem_req), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h2008_0005, 0, 0, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0004, 1'b0};
        vecs[1]  = '{32'h2009_0001, 3, 1, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0008, 1'b0};
        vecs[2]  = '{32'h0109_5020, 3, 2, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_000C, 1'b0};
        vecs[3]  = '{32'h2129_FFFF, 3, 0, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0010, 1'b0};
        vecs[4]  = '{32'h1509_FFFC, 1, 0, 2'b00, 1'b1, 1'b0, 16'hFFFC, 26'h0,  32'h0,         32'h0000_0004, 1'b0};
        vecs[5]  = '{32'h0800_0004, 0, 0, 2'b10, 1'b0, 1'b0, 16'h0000, 26'h4,  32'h0,         32'h0000_0010, 1'b0};
        vecs[6]  = '{32'h1509_FFFC, 0, 1, 2'b00, 1'b1, 1'b1, 16'hFFFC, 26'h0,  32'h0,         32'h0000_0014, 1'b0};
        vecs[7]  = '{32'h0100_0008, 2, 0, 2'b01, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0FFF_FFFC, 32'h0FFF_FFFC, 1'b0};
        vecs[8]  = '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h1000_0000, 1'b0};
        vecs[9]  = '{32'h0800_0040, 0, 0, 2'b10, 1'b0, 1'b0, 16'h0000, 26'h40, 32'h0,         32'h1000_0100, 1'b0};
        vecs[10] = '{32'h0100_0008, 0, 0, 2'b01, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0000_0203, 32'h0000_0200, 1'b1};
        vecs[11] = '{32'h1509_0002, 0, 0, 2'b11, 1'b1, 1'b0, 16'h0002, 26'h0,  32'h0,         32'h0000_020C, 1'b1};
        vecs[12] = '{32'h0C00_0000, 0, 0, 2'b10, 1'b1, 1'b0, 16'h0004, 26'h0,  32'h0,         32'h0000_0000, 1'b1};
        vecs[13] = '{32'h0100_0008, 0, 0, 2'b01, 1'b0, 1'b0, 16'h0000, 26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
        vecs[14] = '{32'h2008_0001, 1, 0, 2'b00, 1'b0, 1'b0, 16'h0000, 26'h0,  32'h0,         32'h0000_0000, 1'b1};
        vecs[15] = '{32'h1509_FFFF, 0, 0, 2'b00, 1'b1, 1'b0, 16'hFFFF, 26'h0,  32'h0,         32'h0000_0000, 1'b1};

        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        instr_ack  = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        jump       = 2'b00;
        immediate  = 16'h0;
        target     = 26'h0;
        jr_addr    = 32'h0;
        model_pc   = 32'h0;
        model_ret  = 32'h0;

        for (int c = 0; c < 3; c++) begin
            step();
            check_output("req_in_reset", 32'(imem_req), 32'd0);
        end
        check_output("reset_pc", pc, 32'h0);
        check_output("reset_instruction", instruction, 32'h0);
        check_output("reset_retired", retired, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            fetch_instr(vecs[i].rdata, vecs[i].mem_wait, model_pc, (i == 0) ? 1 : 0);
            apply_stimulus(vecs[i]);
        end
        check_output("retired_total", retired, 32'd16);

        // Reset while waiting for memory, then a stale ack right after release.
        step();
        rst_n = 1'b0;
        step();
        check_output("rst_fetch_req", 32'(imem_req), 32'd0);
        check_output("rst_fetch_pc", pc, 32'h0);
        check_output("rst_fetch_valid", 32'(instr_valid), 32'd0);
        check_output("rst_fetch_retired", retired, 32'h0);
        check_output("rst_fetch_err", 32'(misalign_err), 32'd0);
        step();
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBADB_AD00;
        step();
        check_output("stale_ack_ignored", 32'(instr_valid), 32'd0);
        check_output("req_after_release", 32'(imem_req), 32'd1);
        imem_ack  = 1'b0;
        model_pc  = 32'h0;
        model_ret = 32'h0;
        fetch_instr(32'h1111_0000, 0, 32'h0, 0);

        // Reset on the same edge as the datapath ack.
        jump      = 2'b10;
        target    = 26'h123;
        instr_ack = 1'b1;
        rst_n     = 1'b0;
        step();
        instr_ack = 1'b0;
        check_output("rst_issue_pc", pc, 32'h0);
        check_output("rst_issue_retired", retired, 32'h0);
        check_output("rst_issue_retired_w4", {28'd0, retired4}, 32'h0);
        check_output("rst_issue_valid", 32'(instr_valid), 32'd0);
        check_output("rst_issue_req", 32'(imem_req), 32'd0);
        check_output("rst_issue_instruction", instruction, 32'h0);
        rst_n = 1'b1;
        fetch_instr(32'h2222_0000, 1, 32'h0, 1);
        apply_stimulus('{32'h0, 0, 0, 2'b00, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h0000_0004, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
